kronos_dmem: RTL and testbench

KRONOS_DMEM -- requirements
Module: kronos_dmem

---
 rtl/kronos_dmem_if.sv | 21 ++
 rtl/kronos_dmem.sv | 112 +++++++++++
 tb/tb_kronos_dmem.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/kronos_dmem_if.sv
// Core-side data bus of the kronos data memory: request fields in, read data and ack out.
// The initiator raises data_req with stable fields and holds it until the single-cycle data_ack.
interface kronos_dmem_if;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic [31:0] data_rd_data;
  logic        data_ack;

  modport master (
    output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    input  data_rd_data, data_ack
  );

  modport slave (
    input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    output data_rd_data, data_ack
  );
endinterface

// File: rtl/kronos_dmem.sv
// Word-addressed single-port data memory behind a req/ack bus (IDLE -> BUSY -> RESP).
// Define KRONOS_DMEM_WAIT_EN to add WAIT_CYCLES extra BUSY cycles before each response.
module kronos_dmem #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rstz,
  kronos_dmem_if.slave     bus,
  output logic [1:0]       dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      mask_q;
  logic            we_q;
  logic            ack_q;
  logic [31:0]     rd_data_q;
  logic [31:0]     mem [DEPTH];
  logic            busy_done;
  logic            access;

`ifdef KRONOS_DMEM_WAIT_EN
  logic [3:0] cnt_q;
  assign busy_done = (cnt_q == 4'd0);
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  assign busy_done = 1'b1;
`endif

  // The access happens on the last BUSY cycle, so read data only changes on entry to RESP.
  assign access = (state_q == BUSY) && busy_done;

  // Byte lane and upper address bits play no part in word selection (addresses alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.data_addr[31:AW+2], bus.data_addr[1:0]};

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wdata_q   <= 32'h0;
      mask_q    <= 4'h0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      rd_data_q <= 32'h0;
`ifdef KRONOS_DMEM_WAIT_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.data_req) begin
            idx_q   <= bus.data_addr[AW+1:2];
            wdata_q <= bus.data_wr_data;
            mask_q  <= bus.data_mask;
            we_q    <= bus.data_wr_en;
            state_q <= BUSY;
`ifdef KRONOS_DMEM_WAIT_EN
            cnt_q   <= 4'(WAIT_CYCLES);
`endif
          end
        end
        BUSY: begin
          if (busy_done) begin
            if (!we_q) begin
              rd_data_q <= mem[idx_q];
            end
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else begin
`ifdef KRONOS_DMEM_WAIT_EN
            cnt_q <= cnt_q - 4'd1;
`endif
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a reset before the access cycle leaves it untouched.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.data_ack     = ack_q;
  assign bus.data_rd_data = rd_data_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_kronos_dmem.sv
// Directed table-driven bench for kronos_dmem: latency, lane masking, aliasing, reset abort, back-to-back.
module tb_kronos_dmem;
  localparam int WAIT = 3;
`ifdef KRONOS_DMEM_WAIT_EN
  localparam int LAT = 2 + WAIT;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rstz;
  logic [1:0] dbg_state;
  kronos_dmem_if bus ();

  kronos_dmem #(.DEPTH(1024), .WAIT_CYCLES(WAIT)) dut (
    .clk         (clk),
    .rstz        (rstz),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One full transaction; request fields are scrambled right after acceptance.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic we, output logic [31:0] rd, output int lat,
                        output logic one_cycle);
    @(negedge clk);
    bus.data_addr    = a;
    bus.data_wr_data = wd;
    bus.data_mask    = m;
    bus.data_wr_en   = we;
    bus.data_req     = 1'b1;
    @(posedge clk);
    #1;
    bus.data_addr    = $urandom;
    bus.data_wr_data = $urandom;
    bus.data_mask    = 4'($urandom_range(0, 15));
    bus.data_wr_en   = ~we;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.data_ack) begin
        lat = n;
        break;
      end
    end
    rd = bus.data_rd_data;
    bus.data_req = 1'b0;
    @(negedge clk);
    one_cycle = !bus.data_ack;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        one;
    int          ack_seen;
    logic [31:0] b2b_addr[4];
    logic [31:0] b2b_exp[4];
    int          k;
    int          n;
    int          last;

    // Writes expect read data to hold the last read value.
    vecs = '{
      '{32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0000_0000},
      '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF},
      '{32'h0000_0020, 32'h11223344, 4'hF, 1'b1, 32'hDEADBEEF},
      '{32'h0000_0020, 32'hAABBCCDD, 4'h5, 1'b1, 32'hDEADBEEF},
      '{32'h0000_0020, 32'h0,        4'h0, 1'b0, 32'h11BB33DD},
      '{32'h0000_1000, 32'h0000_0005, 4'hF, 1'b1, 32'h11BB33DD},
      '{32'h0000_0000, 32'h0,        4'hF, 1'b0, 32'h0000_0005},
      '{32'h0000_0003, 32'h0,        4'h3, 1'b0, 32'h0000_0005},
      '{32'h0000_0020, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0000_0005},
      '{32'h0000_0020, 32'h0,        4'hF, 1'b0, 32'h11BB33DD},
      '{32'h0000_0024, 32'h0,        4'hF, 1'b1, 32'h11BB33DD},
      '{32'h0000_0024, 32'hCAFEF00D, 4'hA, 1'b1, 32'h11BB33DD},
      '{32'h0000_0024, 32'h0,        4'h1, 1'b0, 32'hCA00F000},
      '{32'hFFFF_F010, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF},
      '{32'h0000_0004, 32'h0000_00A1, 4'hF, 1'b1, 32'hDEADBEEF},
      '{32'h0000_0008, 32'h0000_00B2, 4'hF, 1'b1, 32'hDEADBEEF},
      '{32'h0000_000C, 32'h0000_00C3, 4'hF, 1'b1, 32'hDEADBEEF},
      '{32'h0000_0040, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF}
    };

    rstz             = 1'b0;
    bus.data_addr    = 32'h0;
    bus.data_wr_data = 32'h0;
    bus.data_mask    = 4'h0;
    bus.data_wr_en   = 1'b0;
    bus.data_req     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'h0, bus.data_ack}, 32'h0);
    chk("reset_rd_data", bus.data_rd_data, 32'h0);
    chk("reset_state", {30'h0, dbg_state}, 32'h0);
    rstz = 1'b1;

    for (int i = 0; i < 18; i++) begin
      do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].we, rd, lat, one);
      chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
      chk($sformatf("vec%0d_ack_width", i), {31'h0, one}, 32'h1);
    end

    // Reset while BUSY on a write to 0x40: no ack, no commit, read data cleared.
    @(negedge clk);
    bus.data_addr    = 32'h40;
    bus.data_wr_data = 32'hDEADBEEF;
    bus.data_mask    = 4'hF;
    bus.data_wr_en   = 1'b1;
    bus.data_req     = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_abort_state", {30'h0, dbg_state}, 32'h1);
    rstz = 1'b0;
    #1;
    chk("abort_rd_data", bus.data_rd_data, 32'h0);
    chk("abort_ack", {31'h0, bus.data_ack}, 32'h0);
    chk("abort_state", {30'h0, dbg_state}, 32'h0);
    bus.data_req = 1'b0;
    ack_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.data_ack) ack_seen++;
    end
    rstz = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (bus.data_ack) ack_seen++;
    end
    chk("abort_no_ack", ack_seen, 0);
    do_txn(32'h40, 32'h0, 4'hF, 1'b0, rd, lat, one);
    chk("abort_read_0x40", rd, 32'h0);
    chk("post_reset_latency", lat, LAT);

    // Back-to-back reads with data_req held high throughout.
    b2b_addr[0] = 32'h0; b2b_exp[0] = 32'h0000_0005;
    b2b_addr[1] = 32'h4; b2b_exp[1] = 32'h0000_00A1;
    b2b_addr[2] = 32'h8; b2b_exp[2] = 32'h0000_00B2;
    b2b_addr[3] = 32'hC; b2b_exp[3] = 32'h0000_00C3;
    @(negedge clk);
    bus.data_addr  = b2b_addr[0];
    bus.data_mask  = 4'hF;
    bus.data_wr_en = 1'b0;
    bus.data_req   = 1'b1;
    k = 0;
    n = 0;
    last = 0;
    while (k < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.data_ack) begin
        chk($sformatf("b2b%0d_rd", k), bus.data_rd_data, b2b_exp[k]);
        chk($sformatf("b2b%0d_spacing", k), n - last, (k == 0) ? LAT : LAT + 1);
        last = n;
        k++;
        if (k < 4) bus.data_addr = b2b_addr[k];
        else bus.data_req = 1'b0;
      end
    end
    bus.data_req = 1'b0;
    chk("b2b_ack_count", k, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
